// File: rtl/csa_nibble_serial_ctrl.sv
// Nibble-serial WIDTH-bit adder built around one shared 4-bit carry-skip slice.
// Operands are captured on a valid/ready handshake; the result is returned on a second one.

module csa_nibble_serial_ctrl_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout,
    output logic       o_skip
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic       w_c1, w_c2, w_c3, w_c4;

    assign w_p  = i_a ^ i_b;
    assign w_g  = i_a & i_b;
    assign w_c1 = w_g[0] | (w_p[0] & i_cin);
    assign w_c2 = w_g[1] | (w_p[1] & w_c1);
    assign w_c3 = w_g[2] | (w_p[2] & w_c2);
    assign w_c4 = w_g[3] | (w_p[3] & w_c3);

    assign o_sum  = w_p ^ {w_c3, w_c2, w_c1, i_cin};
    // When every bit propagates, the carry-in bypasses the ripple chain.
    assign o_skip = &w_p;
    assign o_cout = o_skip ? i_cin : w_c4;
endmodule

module csa_nibble_serial_ctrl #(
    parameter  int unsigned WIDTH   = 16,
    localparam int unsigned NIBBLES = WIDTH / 4,
    localparam int unsigned CW      = $clog2(NIBBLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [CW-1:0]    skip_cnt
);
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [CW-1:0]    r_skip_cnt;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;
    logic             w_slice_skip;
    logic             w_last;

    assign w_last = (r_idx == IW'(NIBBLES - 1));

    csa_nibble_serial_ctrl_slice u_slice (
        .i_a    (r_a[4*r_idx +: 4]),
        .i_b    (r_b[4*r_idx +: 4]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout),
        .o_skip (w_slice_skip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_skip_cnt  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_skip_cnt <= '0;
                        r_sum      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    r_sum[4*r_idx +: 4] <= w_slice_sum;
                    r_carry             <= w_slice_cout;
                    r_skip_cnt          <= r_skip_cnt + CW'(w_slice_skip);
                    if (w_last) begin
                        r_cout      <= w_slice_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign skip_cnt  = r_skip_cnt;
endmodule

// File: tb/tb_csa_nibble_serial_ctrl.sv
// Directed-vector and random bench for csa_nibble_serial_ctrl at WIDTH=16 and WIDTH=4.

module tb_csa_nibble_serial_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        iv16 = 0, ir16, c16 = 0, ov16, ordy16 = 0, co16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    logic [2:0]  sk16;
    logic        iv4 = 0, ir4, c4 = 0, ov4, ordy4 = 0, co4;
    logic [3:0]  a4 = 0, b4 = 0, s4;
    logic [0:0]  sk4;

    csa_nibble_serial_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(c16), .out_valid(ov16), .out_ready(ordy16), .sum(s16), .cout(co16),
        .skip_cnt(sk16)
    );

    csa_nibble_serial_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .cin(c4), .out_valid(ov4), .out_ready(ordy4), .sum(s4), .cout(co4),
        .skip_cnt(sk4)
    );

    int n_cmp = 0, n_bad = 0;
    int acc16 = 0, hs16 = 0, acc4 = 0, hs4 = 0;
    int iss16 = 0, done16 = 0, iss4 = 0, done4 = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (iv16 && ir16)   acc16 <= acc16 + 1;
            if (ov16 && ordy16) hs16  <= hs16 + 1;
            if (iv4 && ir4)     acc4  <= acc4 + 1;
            if (ov4 && ordy4)   hs4   <= hs4 + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int skips(input logic [15:0] a, input logic [15:0] b, input int nib);
        int n = 0;
        logic [15:0] x;
        x = a ^ b;
        for (int i = 0; i < nib; i++) if (x[4*i +: 4] == 4'hF) n++;
        return n;
    endfunction

    // Present a request once in_ready is up, then scramble inputs after acceptance.
    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic c);
        int t = 0;
        @(negedge clk);
        while (!ir16 && t < 50) begin @(negedge clk); t++; end
        chk("in_ready16_wait", ir16, 1);
        a16 = a; b16 = b; c16 = c; iv16 = 1;
        @(posedge clk); #1;
        iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        iss16++;
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (lat < 30) begin
            @(posedge clk); #1; lat++;
            if (ov16) break;
        end
    endtask

    task automatic finish16(input int stall);
        @(negedge clk);
        ordy16 = 0;
        repeat (stall) @(negedge clk);
        ordy16 = 1;
        @(posedge clk); #1;
        ordy16 = 0;
        done16++;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input int stall,
                       input string tag);
        int t = 0;
        int lat = 0;
        logic [4:0] e;
        @(negedge clk);
        while (!ir4 && t < 50) begin @(negedge clk); t++; end
        a4 = a; b4 = b; c4 = c; iv4 = 1;
        @(posedge clk); #1;
        iv4 = 0; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
        iss4++;
        while (lat < 30) begin
            @(posedge clk); #1; lat++;
            if (ov4) break;
        end
        e = {1'b0, a} + {1'b0, b} + {4'b0, c};
        if (lat != 1 || s4 != e[3:0] || co4 != e[4] || sk4 != 1'((a ^ b) == 4'hF)) begin
            chk({tag, " lat/sum/cout/skip"}, {lat[7:0], 3'b0, co4, s4, 3'b0, sk4},
                {8'd1, 3'b0, e[4], e[3:0], 3'b0, 1'((a ^ b) == 4'hF)});
        end else begin
            n_cmp++;
        end
        @(negedge clk);
        ordy4 = 0;
        repeat (stall) @(negedge clk);
        ordy4 = 1;
        @(posedge clk); #1;
        ordy4 = 0;
        done4++;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic [2:0]  skip;
    } vec_t;

    vec_t vec[9];

    initial begin
        int lat;
        logic [16:0] e;
        logic [15:0] ra, rb;
        logic        rc;

        vec[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 3'd0};
        vec[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd3};
        vec[2] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 3'd4};
        vec[3] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 3'd4};
        vec[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 3'd0};
        vec[5] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 3'd0};
        vec[6] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 3'd2};
        vec[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 3'd4};
        vec[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 3'd0};

        #1 rst_n = 0;
        #2;
        chk("reset in_ready", ir16, 1);
        chk("reset out_valid", ov16, 0);
        chk("reset sum", s16, 0);
        chk("reset cout", co16, 0);
        chk("reset skip_cnt", sk16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            start16(vec[i].a, vec[i].b, vec[i].cin);
            wait16(lat);
            chk($sformatf("v%0d latency", i), lat, 4);
            chk($sformatf("v%0d sum", i), s16, vec[i].sum);
            chk($sformatf("v%0d cout", i), co16, vec[i].cout);
            chk($sformatf("v%0d skip_cnt", i), sk16, vec[i].skip);
            finish16(i % 3);
        end

        // Backpressure with a new request waiting on in_valid.
        start16(16'h1234, 16'h4321, 1'b0);
        wait16(lat);
        @(negedge clk);
        iv16 = 1; a16 = 16'hFFFF; b16 = 16'h0001; c16 = 0; ordy16 = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d out_valid", k), ov16, 1);
            chk($sformatf("bp%0d in_ready", k), ir16, 0);
            chk($sformatf("bp%0d sum", k), s16, 16'h5555);
            chk($sformatf("bp%0d cout/skip", k), {co16, sk16}, 4'h0);
        end
        @(negedge clk);
        ordy16 = 1;
        @(posedge clk); #1;
        ordy16 = 0;
        done16++;
        chk("bp idle in_ready", ir16, 1);
        chk("bp idle out_valid", ov16, 0);
        @(posedge clk); #1;
        chk("bp accept", ir16, 0);
        iv16 = 0; iss16++;
        wait16(lat);
        chk("bp2 latency", lat, 4);
        chk("bp2 result", {co16, sk16, s16}, {1'b1, 3'd3, 16'h0000});
        finish16(0);

        // Abort mid-RUN with asynchronous reset.
        start16(16'h1234, 16'h4321, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst out_valid", ov16, 0);
        chk("rst in_ready", ir16, 1);
        chk("rst sum", s16, 0);
        repeat (3) @(negedge clk);
        chk("rst held out_valid", ov16, 0);
        rst_n = 1;
        start16(16'h0001, 16'h0001, 1'b0);
        wait16(lat);
        chk("post-rst sum", s16, 16'h0002);
        finish16(0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            e  = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            start16(ra, rb, rc);
            wait16(lat);
            if (lat != 4 || s16 != e[15:0] || co16 != e[16] || int'(sk16) != skips(ra, rb, 4))
                chk($sformatf("rnd16 %0d {lat,cout,skip,sum}", i),
                    {lat[7:0], co16, sk16, s16}, {8'd4, e[16], 3'(skips(ra, rb, 4)), e[15:0]});
            else
                n_cmp++;
            finish16($urandom_range(0, 3));
        end

        op4(4'hF, 4'h1, 1'b0, 0, "w4 F+1");
        op4(4'h5, 4'hA, 1'b1, 2, "w4 5+A+1");
        for (int i = 0; i < 1000; i++)
            op4(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3),
                $sformatf("rnd4 %0d", i));

        @(posedge clk); #1;
        chk("handshakes16", hs16, done16);
        chk("accepts16", acc16, iss16);
        chk("handshakes4", hs4, done4);
        chk("accepts4", acc4, iss4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
